// File: rtl/maze_dfs_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : maze_dfs_engine                                            |
// | Description : Depth-first maze solver. Walks a 2**ROW_W x 2**COL_W grid  |
// |               held in an external 1-bit memory (1 = wall or visited),    |
// |               keeps the path as a stack of 2-bit directions in an        |
// |               external FWFT stack, and reports done/fail + path length.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module maze_dfs_engine #(
  parameter int ROW_W    = 4,
  parameter int COL_W    = 4,
  parameter int DEST_ROW = 2**ROW_W-1,
  parameter int DEST_COL = 2**COL_W-1,
  localparam int ADDR_W  = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  input  logic              stk_empty,
  input  logic              stk_full,
  input  logic [1:0]        stk_dout,
  output logic              push,
  output logic              pop,
  output logic [1:0]        din,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W:0]   path_len
);

  // Direction codes, probed in this order.
  localparam logic [1:0] c_dir_up    = 2'd0;
  localparam logic [1:0] c_dir_right = 2'd1;
  localparam logic [1:0] c_dir_down  = 2'd2;
  localparam logic [1:0] c_dir_left  = 2'd3;

  localparam logic [ROW_W-1:0]  c_dest_row = ROW_W'(DEST_ROW);
  localparam logic [COL_W-1:0]  c_dest_col = COL_W'(DEST_COL);
  localparam logic [ROW_W-1:0]  c_last_row = {ROW_W{1'b1}};
  localparam logic [COL_W-1:0]  c_last_col = {COL_W{1'b1}};
  localparam logic [ROW_W-1:0]  c_row_one  = ROW_W'(1);
  localparam logic [COL_W-1:0]  c_col_one  = COL_W'(1);
  localparam logic [ADDR_W:0]   c_len_one  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK0      = 3'd1,
    S_MARK      = 3'd2,
    S_PROBE     = 3'd3,
    S_CHECK     = 3'd4,
    S_BACKTRACK = 3'd5,
    S_DONE      = 3'd6,
    S_FAIL      = 3'd7
  } state_t;

  state_t            r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [1:0]        r_dir;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_fail;
  logic [ADDR_W:0]   r_path_len;

  logic [ROW_W-1:0]  w_nb_row;
  logic [COL_W-1:0]  w_nb_col;
  logic              w_nb_ok;
  logic [ROW_W-1:0]  w_bt_row;
  logic [COL_W-1:0]  w_bt_col;
  logic              w_at_dest;
  logic              w_dir_last;
  logic              w_push;
  logic              w_pop;

  // Neighbour of the current cell in direction r_dir; edges do not wrap.
  always_comb begin
    w_nb_row = r_row;
    w_nb_col = r_col;
    w_nb_ok  = 1'b0;
    case (r_dir)
      c_dir_up: begin
        w_nb_row = r_row - c_row_one;
        w_nb_ok  = (r_row != '0);
      end
      c_dir_right: begin
        w_nb_col = r_col + c_col_one;
        w_nb_ok  = (r_col != c_last_col);
      end
      c_dir_down: begin
        w_nb_row = r_row + c_row_one;
        w_nb_ok  = (r_row != c_last_row);
      end
      default: begin
        w_nb_col = r_col - c_col_one;
        w_nb_ok  = (r_col != '0);
      end
    endcase
  end

  // Cell we came from: one step opposite to the direction on top of the stack.
  always_comb begin
    w_bt_row = r_row;
    w_bt_col = r_col;
    case (stk_dout)
      c_dir_up:    w_bt_row = r_row + c_row_one;
      c_dir_right: w_bt_col = r_col - c_col_one;
      c_dir_down:  w_bt_row = r_row - c_row_one;
      default:     w_bt_col = r_col + c_col_one;
    endcase
  end

  assign w_at_dest  = (r_row == c_dest_row) && (r_col == c_dest_col);
  assign w_dir_last = (r_dir == c_dir_left);

  // Push and pop follow the memory/stack status of the same cycle, so they
  // are decoded from state; they are masked by rst so a reset edge never
  // disturbs the stack.
  assign w_push = (r_state == S_CHECK) && !mem_rdata && !stk_full && !rst;
  assign w_pop  = (r_state == S_BACKTRACK) && !stk_empty && !rst;

  assign push     = w_push;
  assign pop      = w_pop;
  assign din      = w_push ? r_dir : 2'b00;
  assign addr     = r_addr;
  assign we       = r_we;
  assign busy     = r_busy;
  assign done     = r_done;
  assign fail     = r_fail;
  assign path_len = r_path_len;

  // Search controller: state, current cell, probe direction and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_dir      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_path_len <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            r_row      <= '0;
            r_col      <= '0;
            r_dir      <= '0;
            r_addr     <= '0;
            r_path_len <= '0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CHK0;
          end
        end

        S_CHK0: begin
          if (mem_rdata) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAIL;
          end else begin
            // addr already points at (0,0); mark it during MARK
            r_we    <= 1'b1;
            r_state <= S_MARK;
          end
        end

        S_MARK: begin
          if (w_at_dest) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_dir   <= c_dir_up;
            r_state <= S_PROBE;
          end
        end

        S_PROBE: begin
          if (w_nb_ok) begin
            r_addr  <= {w_nb_row, w_nb_col};
            r_state <= S_CHECK;
          end else if (!w_dir_last) begin
            r_dir   <= r_dir + 2'd1;
          end else begin
            r_state <= S_BACKTRACK;
          end
        end

        S_CHECK: begin
          if (!mem_rdata) begin
            if (stk_full) begin
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FAIL;
            end else begin
              // addr still holds the neighbour, which becomes the new cell
              r_row      <= w_nb_row;
              r_col      <= w_nb_col;
              r_path_len <= r_path_len + c_len_one;
              r_we       <= 1'b1;
              r_state    <= S_MARK;
            end
          end else if (!w_dir_last) begin
            r_dir   <= r_dir + 2'd1;
            r_state <= S_PROBE;
          end else begin
            r_state <= S_BACKTRACK;
          end
        end

        S_BACKTRACK: begin
          if (stk_empty) begin
            r_fail  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAIL;
          end else begin
            r_row      <= w_bt_row;
            r_col      <= w_bt_col;
            r_path_len <= r_path_len - c_len_one;
            // A left step exhausts the parent too, so keep unwinding.
            if (stk_dout != c_dir_left) begin
              r_dir   <= stk_dout + 2'd1;
              r_state <= S_PROBE;
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_dfs_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_maze_dfs_engine                                         |
// | Description : Self-checking bench for maze_dfs_engine on a 4x4 grid with |
// |               an algorithmic DFS reference model and randomized mazes.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_maze_dfs_engine;

  localparam int RW = 2;
  localparam int CW = 2;
  localparam int AW = RW + CW;
  localparam int SIDE = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mem_rdata;
  logic [AW-1:0] addr;
  logic          we;
  logic          stk_empty;
  logic          stk_full;
  logic [1:0]    stk_dout;
  logic          push;
  logic          pop;
  logic [1:0]    din;
  logic          busy;
  logic          done;
  logic          fail;
  logic [AW:0]   path_len;

  always #5 clk = ~clk;

  maze_dfs_engine #(.ROW_W(RW), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_rdata(mem_rdata),
    .addr(addr), .we(we), .stk_empty(stk_empty), .stk_full(stk_full),
    .stk_dout(stk_dout), .push(push), .pop(pop), .din(din),
    .busy(busy), .done(done), .fail(fail), .path_len(path_len)
  );

  // Environment: maze memory and FWFT stack.
  logic [15:0] grid;
  logic [1:0]  stk [0:63];
  int          sp;
  int          cap;
  logic        env_load;
  logic [15:0] load_grid;

  assign mem_rdata = grid[addr];
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp >= cap);
  assign stk_dout  = (sp > 0) ? stk[(sp-1) & 63] : 2'b00;

  always @(posedge clk) begin
    if (env_load) begin
      grid <= load_grid;
      sp   <= 0;
    end else begin
      if (we) grid[addr] <= 1'b1;
      if (push && sp < 64) begin
        stk[sp] <= din;
        sp      <= sp + 1;
      end else if (pop && sp > 0) begin
        sp <= sp - 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference results: ordered strobe events (256+addr write, 512+d push,
  // 768+d pop), outcome, and final stack contents.
  int exp_q[$];
  int m_stk[$];
  int m_done, m_fail, m_len;
  int obs_push[$];
  int obs_pop[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int drow(input int d);
    return (d == 0) ? -1 : (d == 2) ? 1 : 0;
  endfunction

  function automatic int dcol(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  // Plain depth-first search over the grid, directions tried 0..3.
  task automatic model_run(input logic [15:0] g, input int c);
    logic [15:0] v;
    int r, cc, d, nr, nc, found, k;
    bit fin;
    int st[$];
    exp_q.delete();
    m_done = 0;
    m_fail = 0;
    v = g;
    if (v[0]) begin
      m_fail = 1;
      m_len  = 0;
      m_stk.delete();
      return;
    end
    r = 0; cc = 0; d = 0; fin = 0;
    v[0] = 1'b1;
    exp_q.push_back(256);
    while (!fin) begin
      if (r == SIDE-1 && cc == SIDE-1) begin
        m_done = 1;
        fin = 1;
      end else begin
        found = -1;
        for (int j = d; j < 4 && found < 0; j++) begin
          nr = r + drow(j);
          nc = cc + dcol(j);
          if (nr >= 0 && nr < SIDE && nc >= 0 && nc < SIDE && !v[nr*SIDE+nc])
            found = j;
        end
        if (found >= 0) begin
          if (st.size() >= c) begin
            m_fail = 1;
            fin = 1;
          end else begin
            st.push_back(found);
            exp_q.push_back(512 + found);
            r  = r + drow(found);
            cc = cc + dcol(found);
            v[r*SIDE+cc] = 1'b1;
            exp_q.push_back(256 + r*SIDE + cc);
            d = 0;
          end
        end else if (st.size() == 0) begin
          m_fail = 1;
          fin = 1;
        end else begin
          k = st.pop_back();
          exp_q.push_back(768 + k);
          r  = r - drow(k);
          cc = cc - dcol(k);
          d  = k + 1;
        end
      end
    end
    m_len = st.size();
    m_stk = st;
  endtask

  // Per-cycle comparison of DUT strobes and depth against the model.
  task automatic cycle_check();
    int n, code;
    if (!rst) begin
      n = int'(push) + int'(pop) + int'(we);
      if (n > 1) begin
        check("strobe_exclusive", n, 1);
      end else if (n == 1) begin
        code = we ? 256 + int'(addr) : push ? 512 + int'(din) : 768 + int'(stk_dout);
        if (push) obs_push.push_back(int'(din));
        if (pop)  obs_pop.push_back(int'(stk_dout));
        if (exp_q.size() == 0) check("unexpected_strobe", code, -1);
        else                   check("strobe_event", code, exp_q.pop_front());
      end
      if (busy) check("depth_vs_stack", int'(path_len), sp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
  endtask

  task automatic load_env(input logic [15:0] g, input int c);
    load_grid = g;
    cap       = c;
    env_load  = 1'b1;
    tick();
    env_load  = 1'b0;
  endtask

  task automatic run_search(input logic [15:0] g, input int c, input int hold, output int cyc);
    load_env(g, c);
    model_run(g, c);
    obs_push.delete();
    obs_pop.delete();
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc >= hold) start = 1'b0;
    end while (!(done || fail) && cyc < 3000);
    start = 1'b0;
    if (!(done || fail)) check("search_timeout", cyc, -1);
    check("done", int'(done), m_done);
    check("fail", int'(fail), m_fail);
    check("path_len", int'(path_len), m_len);
    check("busy_end", int'(busy), 0);
    check("events_left", exp_q.size(), 0);
    check("stack_depth", sp, m_len);
    for (int i = 0; i < m_len && i < 64; i++) check("stack_entry", int'(stk[i]), m_stk[i]);
    repeat (2) tick();
    check("done_hold", int'(done), m_done);
    check("fail_hold", int'(fail), m_fail);
    check("len_hold", int'(path_len), m_len);
  endtask

  initial begin
    int cyc;
    int lit_push[6];
    logic [15:0] g;
    int c, hold;
    lit_push = '{1, 1, 1, 2, 2, 2};

    rst = 1'b1; start = 1'b0; env_load = 1'b1; load_grid = '0; cap = 64;
    tick(); tick();
    env_load = 1'b0;
    tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fail", int'(fail), 0);
    check("rst_len", int'(path_len), 0);
    check("rst_addr", int'(addr), 0);
    check("rst_strobes", int'(push) + int'(pop) + int'(we), 0);
    check("rst_din", int'(din), 0);
    rst = 1'b0;
    tick();

    // Open grid: straight right then down.
    run_search(16'h0000, 64, 1, cyc);
    check("open_push_count", obs_push.size(), 6);
    for (int i = 0; i < 6 && i < obs_push.size(); i++) check("open_push_dir", obs_push[i], lit_push[i]);
    check("open_done", int'(done), 1);
    check("open_len", int'(path_len), 6);

    // Blocked origin.
    run_search(16'h0001, 64, 1, cyc);
    check("origin_cycles", cyc, 2);
    check("origin_fail", int'(fail), 1);
    check("origin_pushes", obs_push.size(), 0);
    check("origin_len", int'(path_len), 0);

    // Target sealed off by (2,3) and (3,2).
    run_search(16'h4800, 64, 1, cyc);
    check("sealed_fail", int'(fail), 1);
    check("sealed_done", int'(done), 0);
    check("sealed_empty", int'(stk_empty), 1);
    check("sealed_len", int'(path_len), 0);

    // Dead-end corridor along row 0.
    run_search(16'h00E0, 64, 1, cyc);
    check("dead_pop_count", obs_pop.size(), 3);
    for (int i = 0; i < 3 && i < obs_pop.size(); i++) check("dead_pop_dir", obs_pop[i], 1);
    check("dead_done", int'(done), 1);
    check("dead_len", int'(path_len), 6);

    // Stack overflow at depth 3.
    run_search(16'h0000, 3, 1, cyc);
    check("ovf_fail", int'(fail), 1);
    check("ovf_len", int'(path_len), 3);
    check("ovf_pushes", obs_push.size(), 3);
    check("ovf_full", int'(stk_full), 1);

    // Reset in the middle of a backtrack, with start asserted alongside.
    load_env(16'h00E0, 64);
    model_run(16'h00E0, 64);
    start = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      start = 1'b0;
    end while (!pop && cyc < 3000);
    if (!pop) check("reach_backtrack", cyc, -1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_fail", int'(fail), 0);
    check("midrst_len", int'(path_len), 0);
    check("midrst_addr", int'(addr), 0);
    rst = 1'b0;
    start = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_idle", int'(busy), 0);
    run_search(16'h00E0, 64, 1, cyc);
    check("after_rst_done", int'(done), 1);
    check("after_rst_len", int'(path_len), 6);

    // Random mazes and stack depths.
    for (int t = 0; t < 40; t++) begin
      g = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 7) != 0) g[0] = 1'b0;
      c = $urandom_range(2, 16);
      hold = g[0] ? 1 : $urandom_range(1, 2);
      run_search(g, c, hold, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maze_dfs_engine.md
MAZE_DFS_ENGINE -- requirements
Module: maze_dfs_engine

Interface
REQ-001 SHALL have parameter ROW_W, default 4, meaning row-index width; grid has 2**ROW_W rows.
REQ-002 SHALL have parameter COL_W, default 4, meaning column-index width; grid has 2**COL_W columns.
REQ-003 SHALL have parameter DEST_ROW, default 2**ROW_W-1, meaning target row.
REQ-004 SHALL have parameter DEST_COL, default 2**COL_W-1, meaning target column.
REQ-005 SHALL have derived localparam ADDR_W = ROW_W+COL_W, meaning cell address width; address = {row,col}.
REQ-006 SHALL have port clk, input, 1, meaning the single clock.
REQ-007 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, meaning begin a search from cell (0,0).
REQ-009 SHALL have port mem_rdata, input, 1, meaning cell data for the address issued last cycle; 1 = wall or visited.
REQ-010 SHALL have port addr, output, ADDR_W, meaning maze memory address.
REQ-011 SHALL have port we, output, 1, meaning maze memory write strobe; write data is constant 1 (visited mark).
REQ-012 SHALL have port stk_empty, input, 1, meaning external stack empty.
REQ-013 SHALL have port stk_full, input, 1, meaning external stack full.
REQ-014 SHALL have port stk_dout, input, 2, meaning stack top, first-word-fall-through.
REQ-015 SHALL have port push, output, 1, meaning stack push strobe.
REQ-016 SHALL have port pop, output, 1, meaning stack pop strobe.
REQ-017 SHALL have port din, output, 2, meaning direction pushed.
REQ-018 SHALL have port busy, output, 1, meaning a search is in progress.
REQ-019 SHALL have port done, output, 1, meaning target reached.
REQ-020 SHALL have port fail, output, 1, meaning no path exists or the stack overflowed.
REQ-021 SHALL have port path_len, output, ADDR_W+1, meaning current stack depth / final path length.

Function
REQ-022 SHALL encode directions as 0=up (row-1), 1=right (col+1), 2=down (row+1), 3=left (col-1), probed in order 0..3.
REQ-023 SHALL implement states IDLE, CHK0, MARK, PROBE, CHECK, BACKTRACK, DONE, FAIL.
REQ-024 SHALL, in IDLE/DONE/FAIL with start=1, clear cur=(0,0), dir=0, path_len=0, done=0, fail=0, drive addr=0 and go to CHK0.
REQ-025 SHALL, in CHK0, go to FAIL if mem_rdata=1, else to MARK.
REQ-026 SHALL, in MARK, assert we for one cycle with addr=cur, then go to DONE if cur=(DEST_ROW,DEST_COL), else set dir=0 and go to PROBE.
REQ-027 SHALL, in PROBE, for an out-of-grid neighbour (no wrap-around), advance dir (REQ-029) without a memory read; otherwise drive addr=neighbour and go to CHECK.
REQ-028 SHALL, in CHECK, with mem_rdata=0: if stk_full go to FAIL with no push; else assert push with din=dir, set cur=neighbour, increment path_len, go to MARK.
REQ-029 SHALL, in CHECK with mem_rdata=1 or on an out-of-grid neighbour: if dir<3 increment dir and go to PROBE, else go to BACKTRACK.
REQ-030 SHALL, in BACKTRACK: if stk_empty go to FAIL; else assert pop, move cur one step opposite to stk_dout, decrement path_len, then go to PROBE with dir=stk_dout+1 if stk_dout<3, else stay in BACKTRACK.
REQ-031 SHALL keep push, pop and we mutually exclusive and each one cycle wide.
REQ-032 SHALL hold done or fail high, and the final path_len, in DONE/FAIL until the next start or rst.
REQ-033 SHALL assert busy in every state except IDLE, DONE and FAIL.
REQ-034 SHALL ignore start while busy.
REQ-035 SHALL, on exit, leave the stack holding the path directions bottom-to-top on done; on fail the stack is empty, except on overflow, where it is full.

Reset
REQ-036 SHALL, on rst=1 at a clock edge in any state including mid-search, enter IDLE with addr=0, cur=(0,0), dir=0, path_len=0 and push, pop, we, din, busy, done, fail = 0.
REQ-037 SHALL give rst priority over start in the same cycle.

Verification
REQ-038 SHALL cover: ROW_W=COL_W=2, all cells free, start -> pushes 1,1,1,2,2,2, done=1, path_len=6, fail=0.
REQ-039 SHALL cover: cell (0,0)=1, start -> fail=1 two cycles after start, zero pushes, path_len=0.
REQ-040 SHALL cover: 4x4 grid, cells (2,3) and (3,2)=1 -> full exploration and backtrack, fail=1, stk_empty=1, path_len=0, done=0.
REQ-041 SHALL cover: 4x4 grid, dead-end corridor (0,1..3) with (1,1..3)=1 and column 0 free -> backtrack pops 1,1,1, then the path completes, done=1, path_len=6.
REQ-042 SHALL cover: rst asserted during BACKTRACK -> next cycle busy=0, done=fail=0, path_len=0; a following start runs normally.
REQ-043 SHALL cover: stack depth 3 with the all-free 4x4 grid -> stk_full with a free neighbour gives fail=1, no 4th push, path_len=3.
